shift_divider: RTL and testbench

Parametrised sequential shift-subtract divider: WIDTH-bit dividend and divisor in, WIDTH-bit quotient and remainder out. It extends the 2×WIDTH remainder/quotient shift register of the Part 3 ALU divider with:

- its own control FSM and a start/done handshake;
- signed and unsigned modes;
- divide-by-zero handling.

It sits beside the multiplier as the ALU's multi-cycle divide unit.

---
 rtl/shift_divider.sv | 167 ++++++++++++++++
 tb/tb_shift_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_divider.sv
// shift_divider -- multi-cycle shift-subtract divide unit for the ALU.
//
// Restoring divider built around a 2*WIDTH remainder/quotient shift register.
// One quotient bit is produced per clock, so a divide takes WIDTH+1 cycles
// from the accepting edge to done. A divide by zero takes 1 cycle.
// Signed operands are converted to magnitudes on entry. The signs are put
// back on the quotient and the remainder in the final cycle. The quotient
// truncates toward zero and the remainder takes the sign of the dividend.
//
// Parameters:
//   WIDTH      operand/result width (4..64)
//   SIGNED_EN  0 removes the signed path; signed_mode is then ignored
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        request, sampled only while busy = 0
//   signed_mode  1 = two's-complement divide, captured with start
//   dividend     captured with start
//   divisor      captured with start
//   busy         high from the accepting edge until the result edge
//   done         one-cycle pulse, results are valid while it is high
//   quotient     registered result, held until the next result
//   remainder    registered result, held until the next result
//   div_by_zero  registered flag for the last result

module shift_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] rq;
  logic [WIDTH-1:0]   dsr;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;
  logic               dz;

  // Operand conditioning for the IDLE -> RUN transfer.
  logic               sgn_op;
  logic               dvd_neg;
  logic               dvs_neg;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic               dvs_zero;

  // One restoring iteration.
  logic [2*WIDTH-1:0] t;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] rq_step;
  logic               cnt_last;

  // Sign restoration for the result write.
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    sgn_op   = SIGNED_EN && signed_mode;
    dvd_neg  = sgn_op & dividend[WIDTH-1];
    dvs_neg  = sgn_op & divisor[WIDTH-1];
    // Magnitudes are unsigned WIDTH-bit values. This keeps |MIN| = 2^(WIDTH-1)
    // exact, so MIN / -1 gives MIN after the sign is put back.
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
    dvs_zero = (divisor == '0);
  end

  always_comb begin
    t        = {rq[2*WIDTH-2:0], 1'b0};
    // The partial remainder is always below 2^(WIDTH-1) before the shift, so
    // no bit is lost out of the top of t. A borrow in diff[WIDTH] means the
    // trial subtraction failed and the shifted value is kept.
    diff     = {1'b0, t[2*WIDTH-1:WIDTH]} - {1'b0, dsr};
    rq_step  = diff[WIDTH] ? t : {diff[WIDTH-1:0], t[WIDTH-1:1], 1'b1};
    cnt_last = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    q_fix = neg_q ? -rq[WIDTH-1:0] : rq[WIDTH-1:0];
    r_fix = neg_r ? -rq[2*WIDTH-1:WIDTH] : rq[2*WIDTH-1:WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rq          <= '0;
      dsr         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (dvs_zero) begin
              // The divide-by-zero result is preloaded into rq with no sign
              // flags, so FIX writes it out unchanged: quotient all ones,
              // remainder equal to the dividend as given.
              rq    <= {dividend, {WIDTH{1'b1}}};
              dsr   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              rq    <= {{WIDTH{1'b0}}, dvd_mag};
              dsr   <= dvs_mag;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          rq  <= rq_step;
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider.sv
// Testbench for shift_divider: a 32-bit signed-capable instance, an 8-bit
// signed-capable instance and an 8-bit unsigned-only instance. Stimulus tasks
// push the expected results and the expected done cycle into per-instance
// queues. Monitors pop from the queues and compare whenever done is seen.

module tb_shift_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          ecyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit instance
  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] quot32, rem32;

  // 8-bit instances share one stimulus
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8s, done8s, dz8s, busy8u, done8u, dz8u;
  logic [7:0]  quot8s, rem8s, quot8u, rem8u;

  item_t q32[$];
  item_t q8s[$];
  item_t q8u[$];

  shift_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) u_div32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .quotient(quot32), .remainder(rem32), .div_by_zero(dz32)
  );

  shift_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) u_div8s (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8s), .done(done8s),
    .quotient(quot8s), .remainder(rem8s), .div_by_zero(dz8s)
  );

  shift_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) u_div8u (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8u), .done(done8u),
    .quotient(quot8u), .remainder(rem8u), .div_by_zero(dz8u)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitors ----------------
  logic  pd32 = 1'b0, pd8s = 1'b0, pd8u = 1'b0;
  item_t it32, it8s, it8u;

  always @(negedge clk) begin
    if (done32) begin
      chk("done32_one_cycle", {63'd0, pd32}, 64'd0);
      chk("busy32_at_done", {63'd0, busy32}, 64'd0);
      if (q32.size() == 0) begin
        fail_now("done32_unexpected");
      end else begin
        it32 = q32.pop_front();
        chk("quot32", {32'd0, quot32}, it32.q);
        chk("rem32", {32'd0, rem32}, it32.r);
        chk("dz32", {63'd0, dz32}, {63'd0, it32.dz});
        chk("lat32", 64'(cyc), 64'(it32.ecyc));
      end
    end
    pd32 = done32;
  end

  always @(negedge clk) begin
    if (done8s) begin
      chk("done8s_one_cycle", {63'd0, pd8s}, 64'd0);
      if (q8s.size() == 0) begin
        fail_now("done8s_unexpected");
      end else begin
        it8s = q8s.pop_front();
        chk("quot8s", {56'd0, quot8s}, it8s.q);
        chk("rem8s", {56'd0, rem8s}, it8s.r);
        chk("dz8s", {63'd0, dz8s}, {63'd0, it8s.dz});
        chk("lat8s", 64'(cyc), 64'(it8s.ecyc));
      end
    end
    pd8s = done8s;
  end

  always @(negedge clk) begin
    if (done8u) begin
      chk("done8u_one_cycle", {63'd0, pd8u}, 64'd0);
      if (q8u.size() == 0) begin
        fail_now("done8u_unexpected");
      end else begin
        it8u = q8u.pop_front();
        chk("quot8u", {56'd0, quot8u}, it8u.q);
        chk("rem8u", {56'd0, rem8u}, it8u.r);
        chk("dz8u", {63'd0, dz8u}, {63'd0, it8u.dz});
        chk("lat8u", 64'(cyc), 64'(it8u.ecyc));
      end
    end
    pd8u = done8u;
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge E0.
  // Done is expected at the negedge after E(lat), i.e. cyc = now + 1 + lat.
  task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz,
                      input bit push);
    item_t e;
    sm32 = sm; a32 = a; b32 = b; start32 = 1'b1;
    e.q = {32'd0, eq}; e.r = {32'd0, er}; e.dz = edz;
    e.ecyc = cyc + 1 + ((b == 32'd0) ? 1 : 33);
    if (push) q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eqs, input logic [7:0] ers,
                     input logic [7:0] equ, input logic [7:0] eru, input logic edz);
    item_t es, eu;
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    es.dz = edz; eu.dz = edz;
    es.ecyc = cyc + 1 + ((b == 8'd0) ? 1 : 9);
    eu.ecyc = es.ecyc;
    es.q = {56'd0, eqs}; es.r = {56'd0, ers};
    eu.q = {56'd0, equ}; eu.r = {56'd0, eru};
    q8s.push_back(es);
    q8u.push_back(eu);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (q32.size() == 0 && q8s.size() == 0 && q8u.size() == 0) break;
      @(negedge clk);
    end
    if (q32.size() != 0 || q8s.size() != 0 || q8u.size() != 0) begin
      fail_now("timeout_waiting_for_done");
      q32.delete(); q8s.delete(); q8u.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy32", {63'd0, busy32}, 64'd0);
    chk("rst_done32", {63'd0, done32}, 64'd0);
    chk("rst_quot32", {32'd0, quot32}, 64'd0);
    chk("rst_rem32", {32'd0, rem32}, 64'd0);
    chk("rst_dz32", {63'd0, dz32}, 64'd0);
    chk("rst_busy8s", {63'd0, busy8s}, 64'd0);

    // Release reset and request on the same negedge: the first rising edge
    // with rst high must accept. Then check busy over E0..E32.
    rst = 1'b1;
    op32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) begin
      chk("busy32_during_op", {63'd0, busy32}, 64'd1);
      @(negedge clk);
    end
    wait_idle();

    // Signed 32-bit
    op32(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_idle();
    op32(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
    wait_idle();
    op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // Divide by zero, then a valid divide clears the flag
    op32(1'b0, 32'd16, 32'd0, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1);
    wait_idle();
    op32(1'b1, 32'd16, 32'd0, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1);
    wait_idle();
    op32(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    wait_idle();

    // Start pulses at E5 and during FIX (E33) are ignored
    op32(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (27) @(negedge clk);
    a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_idle();

    // Start held across done: second op accepted on the done edge (E34)
    sm32 = 1'b0; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
    q32.push_back('{64'd10, 64'd0, 1'b0, cyc + 34});
    q32.push_back('{64'd9, 64'd5, 1'b0, cyc + 68});
    @(negedge clk);
    a32 = 32'd77; b32 = 32'd8;
    repeat (34) @(negedge clk);
    start32 = 1'b0;
    wait_idle();

    // Reset at E10 of 12/4: outputs clear at once, no done afterwards
    op32(1'b0, 32'd12, 32'd4, 32'd3, 32'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy32", {63'd0, busy32}, 64'd0);
    chk("midrst_done32", {63'd0, done32}, 64'd0);
    chk("midrst_quot32", {32'd0, quot32}, 64'd0);
    chk("midrst_rem32", {32'd0, rem32}, 64'd0);
    chk("midrst_dz32", {63'd0, dz32}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    op32(1'b0, 32'd12, 32'd4, 32'd3, 32'd0, 1'b0, 1'b1);
    wait_idle();

    // 8-bit instances: signed-capable / unsigned-only expectations
    op8(1'b0, 8'd255, 8'd16, 8'd15, 8'd15, 8'd15, 8'd15, 1'b0);
    wait_idle();
    op8(1'b1, 8'h80, 8'd3, 8'hD6, 8'hFE, 8'h2A, 8'h02, 1'b0);
    wait_idle();
    op8(1'b1, 8'hF9, 8'd2, 8'hFD, 8'hFF, 8'h7C, 8'h01, 1'b0);
    wait_idle();
    op8(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 8'h00, 8'h07, 1'b0);
    wait_idle();
    op8(1'b1, 8'h10, 8'h00, 8'hFF, 8'h10, 8'hFF, 8'h10, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
